count_wrap_monitor: RTL and testbench
=====================================

COUNT_WRAP_MONITOR -- requirements
Module: count_wrap_monitor

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, number of event FIFO entries (power of two, >=2).
REQ-002 SHALL have parameter STAMP_W, default 8, width of the cycle timestamp and wrap counter.
REQ-003 SHALL have port clk  input  1  single clock; all logic on posedge clk.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port up  input  1  counter direction, same signal that drives the 4-bit up/down counter.
REQ-006 SHALL have port din  input  4  counter dout being monitored.
REQ-007 SHALL have port evt_valid  output  1  event FIFO non-empty.
REQ-008 SHALL have port evt_ready  input  1  consumer accepts head event.
REQ-009 SHALL have port evt_dir  output  1  head event direction: 1 = up-wrap (15->0), 0 = down-wrap (0->15).
REQ-010 SHALL have port evt_stamp  output  STAMP_W  head event timestamp.
REQ-011 SHALL have port wrap_cnt  output  STAMP_W  total detected wraps, saturating.
REQ-012 SHALL have port ovf  output  1  sticky flag: at least one event dropped on full FIFO.
REQ-013 SHALL have port clr_ovf  input  1  clears ovf.
REQ-014 SHALL have port level  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Function
REQ-015 SHALL register din into prev_q and up into up_q every cycle, and set prev_vld one cycle after reset deasserts.
REQ-016 SHALL detect an up-wrap at an edge when prev_vld=1, up_q=1, prev_q=15, din=0.
REQ-017 SHALL detect a down-wrap at an edge when prev_vld=1, up_q=0, prev_q=0, din=15.
REQ-018 SHALL ignore all other transitions, including 15->0 with up_q=0 and any non-±1 jump.
REQ-019 SHALL run a free-running STAMP_W-bit cycle counter, 0 after reset, wrapping modulo 2^STAMP_W.
REQ-020 SHALL push {dir, stamp} at the detecting edge; evt_valid rises the following cycle (latency 1).
REQ-021 SHALL pop the head on any edge with evt_valid=1 and evt_ready=1; evt_dir/evt_stamp hold stable while evt_valid=1 and evt_ready=0.
REQ-022 SHALL, when FIFO is full and a pop occurs on the same edge as a push, accept the push (level unchanged).
REQ-023 SHALL, when FIFO is full with no pop, drop the new event and set ovf.
REQ-024 SHALL ignore evt_ready when empty; level never underflows.
REQ-025 SHALL increment wrap_cnt on every detected wrap (pushed or dropped), saturating at 2^STAMP_W-1.
REQ-026 SHALL clear ovf on clr_ovf=1; a drop on the same edge as clr_ovf leaves ovf=1.

Reset
REQ-027 SHALL on rst=1 at an edge set evt_valid=0, level=0, wrap_cnt=0, ovf=0, stamp=0, prev_vld=0, FIFO pointers=0.
REQ-028 SHALL detect no wrap on the first edge after reset deasserts (prev_vld=0), so counter reset to 0 never counts.
REQ-029 SHALL discard all queued events when rst asserts mid-operation.

Structure
REQ-030 SHALL place CNT_W=4, default STAMP_W, default FIFO_DEPTH and the event struct type {dir, stamp} in package count_mon_pkg.
REQ-031 SHALL implement the FIFO as sub-module wrap_evt_fifo (valid/ready pop, push/full/level, synchronous reset).

Verification
REQ-032 SHALL cover: rst 3 cycles, up=1, counter runs 0..15->0 -> one event dir=1, stamp = cycle of detecting edge, wrap_cnt=1.
REQ-033 SHALL cover: up=0 from din=1 -> 1,0,15 -> one event dir=0; wrap_cnt increments by 1.
REQ-034 SHALL cover: evt_ready=0, 5 up-wraps with FIFO_DEPTH=4 -> level=4, ovf=1, wrap_cnt=5, head stamp = first wrap.
REQ-035 SHALL cover: FIFO full, evt_ready=1 on same edge as new wrap -> level stays 4, new event at tail, ovf unchanged.
REQ-036 SHALL cover: rst asserted with din=15 then counter forced to 0 -> no event, level=0, wrap_cnt=0.
REQ-037 SHALL cover: clr_ovf=1 while ovf=1, no drop -> ovf=0 next cycle; clr_ovf with simultaneous drop -> ovf=1.

Source files
------------

// File: rtl/count_mon_pkg.sv
// Shared constants and event payload layout for the counter wrap monitor.
//   CNT_W          : width of the monitored up/down counter
//   DEF_STAMP_W    : default timestamp / wrap counter width
//   DEF_FIFO_DEPTH : default event FIFO depth
//   wrap_evt_t     : {dir, stamp} event record at the default stamp width
package count_mon_pkg;

  localparam int unsigned CNT_W          = 4;
  localparam int unsigned DEF_STAMP_W    = 8;
  localparam int unsigned DEF_FIFO_DEPTH = 4;

  // dir = 1 for an up-wrap (15->0), 0 for a down-wrap (0->15)
  typedef struct packed {
    logic                   dir;
    logic [DEF_STAMP_W-1:0] stamp;
  } wrap_evt_t;

endpackage

// File: rtl/wrap_evt_fifo.sv
// Small synchronous FIFO for wrap events with valid/ready pop side.
//   clk, rst   : clock and synchronous active-high reset
//   push       : write push_data this edge (accepted unless full without pop)
//   push_data  : event payload
//   full_c     : combinational full indication
//   valid      : registered, FIFO non-empty
//   ready      : consumer pops head when valid
//   data       : head payload, stable while valid and not popped
//   level      : registered occupancy
module wrap_evt_fifo #(
  parameter  int unsigned DEPTH  = 4,
  parameter  int unsigned DATA_W = 9,
  localparam int unsigned PTR_W  = $clog2(DEPTH),
  localparam int unsigned LVL_W  = PTR_W + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  output logic              full_c,
  output logic              valid,
  input  logic              ready,
  output logic [DATA_W-1:0] data,
  output logic [LVL_W-1:0]  level
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [LVL_W-1:0]  r_level;
  logic              r_valid;

  logic              w_pop;
  logic              w_acc;
  logic [LVL_W-1:0]  w_level_nxt;

  assign w_pop  = r_valid & ready;
  assign full_c = (r_level == LVL_W'(DEPTH));
  // A pop on the same edge frees a slot, so a full FIFO still takes the push
  assign w_acc  = push & (~full_c | w_pop);
  assign w_level_nxt = r_level + LVL_W'(w_acc) - LVL_W'(w_pop);

  // Pointers, occupancy and valid flag
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      r_valid  <= 1'b0;
    end else begin
      if (w_acc) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      r_level <= w_level_nxt;
      r_valid <= (w_level_nxt != '0);
    end
  end

  // Storage array; contents are don't-care until written
  always_ff @(posedge clk) begin
    if (w_acc) r_mem[r_wr_ptr] <= push_data;
  end

  assign data  = r_mem[r_rd_ptr];
  assign valid = r_valid;
  assign level = r_level;

endmodule

// File: rtl/count_wrap_monitor.sv
// Watches a 4-bit up/down counter and logs each wrap (15->0 going up,
// 0->15 going down) with a cycle timestamp into an event FIFO.
//   clk, rst   : clock and synchronous active-high reset
//   up, din    : counter direction and value being monitored
//   evt_*      : FIFO head (valid/ready, direction, timestamp)
//   wrap_cnt   : saturating count of all detected wraps
//   ovf        : sticky drop flag, cleared by clr_ovf
//   level      : FIFO occupancy
module count_wrap_monitor
  import count_mon_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int unsigned STAMP_W    = DEF_STAMP_W
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        up,
  input  logic [CNT_W-1:0]            din,
  output logic                        evt_valid,
  input  logic                        evt_ready,
  output logic                        evt_dir,
  output logic [STAMP_W-1:0]          evt_stamp,
  output logic [STAMP_W-1:0]          wrap_cnt,
  output logic                        ovf,
  input  logic                        clr_ovf,
  output logic [$clog2(FIFO_DEPTH):0] level
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam int unsigned      EVT_W   = STAMP_W + 1;

  logic [CNT_W-1:0]   r_prev;
  logic               r_up_q;
  logic               r_prev_vld;
  logic [STAMP_W-1:0] r_stamp;
  logic [STAMP_W-1:0] r_wrap_cnt;
  logic               r_ovf;

  logic               w_wrap_up;
  logic               w_wrap_dn;
  logic               w_wrap;
  logic               w_full;
  logic               w_pop;
  logic               w_drop;
  logic [EVT_W-1:0]   w_push_data;
  logic [EVT_W-1:0]   w_head;

  // Wrap detection compares the previous sample against the current one;
  // r_prev_vld masks the first edge after reset so a counter reset is ignored
  assign w_wrap_up = r_prev_vld &  r_up_q & (r_prev == CNT_MAX) & (din == '0);
  assign w_wrap_dn = r_prev_vld & ~r_up_q & (r_prev == '0)      & (din == CNT_MAX);
  assign w_wrap    = w_wrap_up | w_wrap_dn;

  assign w_pop       = evt_valid & evt_ready;
  assign w_drop      = w_wrap & w_full & ~w_pop;
  assign w_push_data = {w_wrap_up, r_stamp};

  // Sample history is captured every cycle, reset or not
  always_ff @(posedge clk) begin
    r_prev <= din;
    r_up_q <= up;
  end

  // Timestamp, wrap count and sticky overflow
  always_ff @(posedge clk) begin
    if (rst) begin
      r_prev_vld <= 1'b0;
      r_stamp    <= '0;
      r_wrap_cnt <= '0;
      r_ovf      <= 1'b0;
    end else begin
      r_prev_vld <= 1'b1;
      r_stamp    <= r_stamp + STAMP_W'(1);
      if (w_wrap && (r_wrap_cnt != '1)) r_wrap_cnt <= r_wrap_cnt + STAMP_W'(1);
      // A drop wins over a simultaneous clear
      if (w_drop)       r_ovf <= 1'b1;
      else if (clr_ovf) r_ovf <= 1'b0;
    end
  end

  wrap_evt_fifo #(
    .DEPTH  (FIFO_DEPTH),
    .DATA_W (EVT_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (w_wrap),
    .push_data (w_push_data),
    .full_c    (w_full),
    .valid     (evt_valid),
    .ready     (evt_ready),
    .data      (w_head),
    .level     (level)
  );

  assign evt_dir   = w_head[STAMP_W];
  assign evt_stamp = w_head[STAMP_W-1:0];
  assign wrap_cnt  = r_wrap_cnt;
  assign ovf       = r_ovf;

endmodule

// File: tb/tb_count_wrap_monitor.sv
// Randomised and directed bench for count_wrap_monitor against a queue model.
module tb_count_wrap_monitor;
  import count_mon_pkg::*;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned SW    = 8;
  localparam int unsigned LW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          up = 1'b1;
  logic [3:0]    din = 4'd0;
  logic          evt_ready = 1'b0;
  logic          clr_ovf = 1'b0;
  logic          evt_valid;
  logic          evt_dir;
  logic [SW-1:0] evt_stamp;
  logic [SW-1:0] wrap_cnt;
  logic          ovf;
  logic [LW-1:0] level;

  int total = 0;
  int bad   = 0;

  count_wrap_monitor #(.FIFO_DEPTH(DEPTH), .STAMP_W(SW)) dut (
    .clk       (clk),
    .rst       (rst),
    .up        (up),
    .din       (din),
    .evt_valid (evt_valid),
    .evt_ready (evt_ready),
    .evt_dir   (evt_dir),
    .evt_stamp (evt_stamp),
    .wrap_cnt  (wrap_cnt),
    .ovf       (ovf),
    .clr_ovf   (clr_ovf),
    .level     (level)
  );

  always #5 clk = ~clk;

  // Reference model: event list, cycle count since reset, previous sample
  wrap_evt_t   q[$];
  int unsigned m_cycles = 0;
  int unsigned m_wraps  = 0;
  bit          m_ovf    = 1'b0;
  bit          m_seen   = 1'b0;
  bit          m_live   = 1'b0;
  int          m_prev   = 0;
  bit          m_up     = 1'b0;
  bit          m_wu, m_wd, m_drop;

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    if (rst) begin
      q.delete();
      m_cycles = 0;
      m_wraps  = 0;
      m_ovf    = 1'b0;
      m_seen   = 1'b0;
      m_live   = 1'b1;
    end else begin
      m_wu   = m_seen &&  m_up && m_prev == 15 && din == 4'd0;
      m_wd   = m_seen && !m_up && m_prev == 0  && din == 4'd15;
      m_drop = 1'b0;
      if (q.size() != 0 && evt_ready) void'(q.pop_front());
      if (m_wu || m_wd) begin
        if (m_wraps < 255) m_wraps++;
        if (q.size() < DEPTH) q.push_back('{dir: m_wu, stamp: SW'(m_cycles % 256)});
        else m_drop = 1'b1;
      end
      if (m_drop)       m_ovf = 1'b1;
      else if (clr_ovf) m_ovf = 1'b0;
      m_cycles++;
      m_seen = 1'b1;
    end
    m_prev = int'(din);
    m_up   = up;
  end

  // Every-cycle comparison of DUT outputs against the model
  always @(negedge clk) begin
    if (m_live) begin
      check("evt_valid", evt_valid, q.size() != 0);
      check("level", level, q.size());
      check("wrap_cnt", wrap_cnt, m_wraps);
      check("ovf", ovf, m_ovf);
      if (q.size() != 0) begin
        check("evt_dir", evt_dir, q[0].dir);
        check("evt_stamp", evt_stamp, q[0].stamp);
      end
    end
  end

  task automatic step(input logic r, input logic u, input logic [3:0] d,
                      input logic rdy, input logic clr);
    rst       = r;
    up        = u;
    din       = d;
    evt_ready = rdy;
    clr_ovf   = clr;
    @(posedge clk);
    @(negedge clk);
  endtask

  int cnt;
  bit dir_up;

  initial begin
    // Reset 3 cycles, then count 0..15 and wrap to 0
    repeat (3) step(1, 1, 4'd0, 0, 0);
    check("rst_level", level, 0);
    check("rst_valid", evt_valid, 0);
    check("rst_wrap_cnt", wrap_cnt, 0);
    check("rst_ovf", ovf, 0);
    for (int i = 0; i < 16; i++) step(0, 1, 4'(i), 0, 0);
    check("up_wrap_none_yet", evt_valid, 0);
    step(0, 1, 4'd0, 0, 0);
    check("up_wrap_valid", evt_valid, 1);
    check("up_wrap_dir", evt_dir, 1);
    check("up_wrap_stamp", evt_stamp, 16);
    check("up_wrap_cnt", wrap_cnt, 1);
    check("model_up_stamp", (q.size() != 0) ? longint'(q[0].stamp) : -1, 16);

    // Pop, then count down 1,0,15
    step(0, 1, 4'd0, 1, 0);
    check("pop_level", level, 0);
    step(0, 0, 4'd1, 0, 0);
    step(0, 0, 4'd0, 0, 0);
    step(0, 0, 4'd15, 0, 0);
    check("dn_wrap_valid", evt_valid, 1);
    check("dn_wrap_dir", evt_dir, 0);
    check("dn_wrap_stamp", evt_stamp, 20);
    check("dn_wrap_cnt", wrap_cnt, 2);

    // Five up-wraps into a depth-4 FIFO with no consumer
    step(1, 1, 4'd0, 0, 0);
    for (int k = 0; k < 5; k++) begin
      step(0, 1, 4'd15, 0, 0);
      step(0, 1, 4'd0, 0, 0);
    end
    check("full_level", level, 4);
    check("full_ovf", ovf, 1);
    check("full_wrap_cnt", wrap_cnt, 5);
    check("full_head_stamp", evt_stamp, 1);

    // Full FIFO: pop and push on the same edge
    step(0, 1, 4'd15, 0, 0);
    step(0, 1, 4'd0, 1, 0);
    check("pp_level", level, 4);
    check("pp_ovf", ovf, 1);
    check("pp_head_stamp", evt_stamp, 3);
    check("pp_wrap_cnt", wrap_cnt, 6);
    repeat (3) step(0, 1, 4'd0, 1, 0);
    check("pp_tail_stamp", evt_stamp, 11);
    check("pp_tail_level", level, 1);

    // Clear without a drop, then clear racing a drop
    step(0, 1, 4'd0, 0, 1);
    check("clr_ovf", ovf, 0);
    for (int k = 0; k < 3; k++) begin
      step(0, 1, 4'd15, 0, 0);
      step(0, 1, 4'd0, 0, 0);
    end
    check("refill_level", level, 4);
    check("refill_ovf", ovf, 0);
    step(0, 1, 4'd15, 0, 0);
    step(0, 1, 4'd0, 0, 1);
    check("clr_vs_drop_ovf", ovf, 1);
    check("clr_vs_drop_cnt", wrap_cnt, 10);

    // Reset with din=15, counter then forced to 0
    step(1, 1, 4'd15, 0, 0);
    step(0, 1, 4'd0, 0, 0);
    check("rst15_valid", evt_valid, 0);
    check("rst15_level", level, 0);
    check("rst15_wrap_cnt", wrap_cnt, 0);

    // Random counter-like traffic with jumps, direction flips and resets
    cnt = 0;
    dir_up = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 15) == 0) dir_up = ~dir_up;
      if ($urandom_range(0, 40) == 0) cnt = int'($urandom_range(0, 15));
      else cnt = dir_up ? (cnt + 1) % 16 : (cnt + 15) % 16;
      step(($urandom_range(0, 400) == 0), dir_up, 4'(cnt),
           ($urandom_range(0, 3) == 0), ($urandom_range(0, 19) == 0));
    end

    // Dense wraps to drive wrap_cnt into saturation
    step(1, 1, 4'd0, 0, 0);
    for (int i = 0; i < 300; i++) begin
      step(0, 1, 4'd15, ($urandom_range(0, 1) == 1), ($urandom_range(0, 9) == 0));
      step(0, 1, 4'd0, ($urandom_range(0, 1) == 1), 0);
    end
    check("sat_wrap_cnt", wrap_cnt, 255);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
